// File: rtl/bus_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_round_robin_arbiter
//  Description : Round-robin owner selection for a single shared memory bus.
//                Issues one read/write strobe per transfer, waits for the
//                matching done strobe (or a timeout) and pulses done/err
//                back to the owning requester.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_round_robin_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_read,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          err,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         addr_out,
  output logic [DATA_W-1:0]         data_out,
  output logic                      read_q,
  output logic                      write_q,
  input  logic                      read_dn,
  input  logic                      write_dn,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      is_bus_busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int PW1   = PTR_W + 1;
  localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [PW1-1:0]   c_N_WIDE   = PW1'(N_REQ);
  localparam logic [15:0]      c_TIMEOUT  = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic                 is_rd_q;
  logic [15:0]          timer_q;
  logic [N_REQ-1:0]     grant_q;
  logic [N_REQ-1:0]     done_q;
  logic [N_REQ-1:0]     err_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [ADDR_W-1:0]    addr_out_q;
  logic [DATA_W-1:0]    data_out_q;
  logic                 rd_stb_q;
  logic                 wr_stb_q;
  logic                 busy_q;

  logic [N_REQ-1:0]     pend;
  logic                 win_vld_d;
  logic [PTR_W-1:0]     win_idx_d;
  logic [PW1-1:0]       cand;
  logic [N_REQ-1:0]     win_onehot;
  logic [PTR_W-1:0]     ptr_d;
  logic [15:0]          timer_d;
  logic                 dn_match;
  logic                 timeout_hit;

  logic [ADDR_W-1:0]    slot_addr  [N_REQ];
  logic [DATA_W-1:0]    slot_wdata [N_REQ];

  // Split the packed per-requester buses into indexable slots
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign slot_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign slot_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign pend        = req_read | req_write;
  assign win_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_d;
  assign ptr_d       = (owner_q == c_LAST_IDX) ? '0 : owner_q + 1'b1;
  assign timer_d     = timer_q + 16'd1;
  assign timeout_hit = (timer_d == c_TIMEOUT);
  assign dn_match    = is_rd_q ? read_dn : write_dn;

  // Round-robin search: walk offsets high-to-low so the closest pending slot
  // at or after the pointer is the last one written and therefore wins
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand      = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_q} + PW1'(off);
      if (cand >= c_N_WIDE) begin
        cand = cand - c_N_WIDE;
      end
      if (pend[cand[PTR_W-1:0]]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand[PTR_W-1:0];
      end
    end
  end

  // Transfer FSM; every bus- and requester-facing output is a register here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      is_rd_q    <= 1'b0;
      timer_q    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q   <= '0;
      err_q    <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            owner_q    <= win_idx_d;
            // read takes precedence when both request lines are up
            is_rd_q    <= req_read[win_idx_d];
            grant_q    <= win_onehot;
            busy_q     <= 1'b1;
            addr_out_q <= slot_addr[win_idx_d];
            if (req_read[win_idx_d]) begin
              rd_stb_q <= 1'b1;
            end else begin
              wr_stb_q   <= 1'b1;
              data_out_q <= slot_wdata[win_idx_d];
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (dn_match) begin
            if (is_rd_q) begin
              rdata_q <= data_in;
            end
            done_q     <= grant_q;
            busy_q     <= 1'b0;
            addr_out_q <= '0;
            data_out_q <= '0;
            timer_q    <= '0;
            state_q    <= S_DONE;
          end else if ((state_q == S_WAIT) && timeout_hit) begin
            err_q      <= grant_q;
            busy_q     <= 1'b0;
            addr_out_q <= '0;
            data_out_q <= '0;
            timer_q    <= '0;
            state_q    <= S_DONE;
          end else begin
            // the issue cycle itself does not count toward the timeout
            if (state_q == S_WAIT) begin
              timer_q <= timer_d;
            end
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          grant_q <= '0;
          ptr_q   <= ptr_d;
          timer_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign addr_out    = addr_out_q;
  assign data_out    = data_out_q;
  assign read_q      = rd_stb_q;
  assign write_q     = wr_stb_q;
  assign is_bus_busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_round_robin_arbiter
//  Description : Self-checking bench for bus_round_robin_arbiter (4 requesters,
//                timeout 8): directed vector table, hand sequences for
//                fairness and mid-transfer reset, then randomized traffic
//                against a transaction-level round-robin model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_round_robin_arbiter;

  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_read, req_write;
  logic [127:0]  req_addr, req_wdata;
  logic [3:0]    grant, done, err;
  logic [31:0]   rdata, addr_out, data_out, data_in;
  logic          read_q, write_q, read_dn, write_dn, is_bus_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rd;
  int done_cnt [4];

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    int          dly;   // cycles after the strobe until dn; negative = never
    bit          mm;    // drive the non-matching dn while waiting
    logic [3:0]  eg;    // expected grant
    bit          erd;   // expected op is read
    logic [31:0] rv;    // data returned on the bus
  } vec_t;

  vec_t tab [10];

  bus_round_robin_arbiter #(
    .N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .done(done), .err(err), .rdata(rdata),
    .addr_out(addr_out), .data_out(data_out),
    .read_q(read_q), .write_q(write_q),
    .read_dn(read_dn), .write_dn(write_dn), .data_in(data_in),
    .is_bus_busy(is_bus_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  function automatic logic [14:0] ctl();
    return {grant, done, err, is_bus_busy, read_q, write_q};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One complete transfer: request, strobe, optional wait/mismatch, end pulse
  task automatic xfer(input vec_t v, input bit keep);
    bit seen;
    int w;
    int nwait;
    logic [31:0] exp_wd;
    req_read  = v.rd;
    req_write = v.wr;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(posedge clk); #1;
      seen = read_q | write_q;
      if (!seen) check("idle_outputs", {grant, is_bus_busy, done, err}, 13'd0);
    end
    check("strobe_seen", seen, 1'b1);
    if (!seen) begin
      req_read  = '0;
      req_write = '0;
      return;
    end
    w = 0;
    for (int i = 0; i < 4; i++) if (v.eg[i]) w = i;
    exp_wd = v.erd ? 32'h0 : req_wdata[w*32 +: 32];
    check("issue_ctl", ctl(), {v.eg, 8'h00, 1'b1, v.erd, !v.erd});
    check("issue_addr", addr_out, req_addr[w*32 +: 32]);
    check("issue_wdata", data_out, exp_wd);
    nwait = (v.dly < 0) ? TO : v.dly;
    for (int k = 0; k < nwait; k++) begin
      if (v.mm) begin
        if (v.erd) write_dn = 1'b1; else read_dn = 1'b1;
        data_in = 32'hBAD0_0000 | k;
      end
      @(posedge clk); #1;
      read_dn = 1'b0; write_dn = 1'b0; data_in = '0;
      check("wait_ctl", ctl(), {v.eg, 8'h00, 1'b1, 2'b00});
      check("wait_bus", {addr_out, data_out}, {req_addr[w*32 +: 32], exp_wd});
    end
    if (v.dly >= 0) begin
      if (v.erd) read_dn = 1'b1; else write_dn = 1'b1;
      data_in = v.rv;
    end else if (v.mm) begin
      if (v.erd) write_dn = 1'b1; else read_dn = 1'b1;
      data_in = 32'hBAD0_FFFF;
    end
    @(posedge clk); #1;
    read_dn = 1'b0; write_dn = 1'b0; data_in = '0;
    check("end_ctl", ctl(), {v.eg, (v.dly >= 0) ? v.eg : 4'b0, (v.dly < 0) ? v.eg : 4'b0, 3'b000});
    check("end_bus", {addr_out, data_out}, 64'h0);
    if (v.erd && v.dly >= 0) last_rd = v.rv;
    check("end_rdata", rdata, last_rd);
    for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
    if (!keep) begin
      req_read  = v.rd & ~v.eg;
      req_write = v.wr & ~v.eg;
    end
  endtask

  // Random-phase state (single process)
  int          c, idle_from, s, d, exp_end, mptr, w;
  bit          in_xfer, never, w_rd, exp_stb;
  logic [3:0]  prev_pend, act, drop;
  int          opk [4];
  logic [31:0] ra [4], rw [4];
  logic [31:0] exp_rd;
  logic [3:0]  eg;
  bit          seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{4'b1001, 4'b0010,  1, 1'b0, 4'b0001, 1'b1, 32'h1111_0000};
    tab[1] = '{4'b1000, 4'b0010,  2, 1'b0, 4'b0010, 1'b0, 32'h0000_0000};
    tab[2] = '{4'b1000, 4'b0000,  0, 1'b0, 4'b1000, 1'b1, 32'h2222_0002};
    tab[3] = '{4'b1111, 4'b0000,  1, 1'b0, 4'b0001, 1'b1, 32'h3333_0003};
    tab[4] = '{4'b0100, 4'b0000,  3, 1'b0, 4'b0100, 1'b1, 32'hDEAD_BEEF};
    tab[5] = '{4'b0011, 4'b0011,  2, 1'b1, 4'b0001, 1'b1, 32'h5555_0005};
    tab[6] = '{4'b0000, 4'b1100, -1, 1'b0, 4'b0100, 1'b0, 32'h0000_0000};
    tab[7] = '{4'b0000, 4'b1000,  1, 1'b0, 4'b1000, 1'b0, 32'h0000_0000};
    tab[8] = '{4'b0001, 4'b0000, -1, 1'b1, 4'b0001, 1'b1, 32'h0000_0000};
    tab[9] = '{4'b0101, 4'b0000,  1, 1'b0, 4'b0100, 1'b1, 32'h9999_0009};

    rst = 1'b1;
    req_read = '0; req_write = '0;
    read_dn = 1'b0; write_dn = 1'b0; data_in = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = 32'h100 ^ (32'(i ^ 2) << 12);
      req_wdata[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
      done_cnt[i] = 0;
    end
    last_rd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 4'h0);
    check("rst_pulses", {done, err}, 8'h00);
    check("rst_strobes", {read_q, write_q, is_bus_busy}, 3'b000);
    check("rst_bus", {addr_out, data_out, rdata}, 96'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int t = 0; t < 10; t++) xfer(tab[t], 1'b0);

    // Fairness: all four hold read requests for 12 transfers, pointer at 3
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    for (int t = 0; t < 12; t++) begin
      eg = oh((3 + t) % 4);
      xfer('{4'b1111, 4'b0000, 1, 1'b0, eg, 1'b1, 32'h0F00_0000 + 32'(t)}, 1'b1);
    end
    for (int i = 0; i < 4; i++) check("fair_count", done_cnt[i], 3);

    // Reset in the middle of WAIT, then the pointer restarts at 0
    req_read = 4'b1010; req_write = 4'b0000;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(posedge clk); #1;
      seen = read_q;
    end
    check("rstmid_pre_grant", grant, 4'b1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("rstmid_async_clear",
          {grant, done, err, read_q, write_q, is_bus_busy, addr_out, data_out, rdata}, 111'h0);
    last_rd = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rstmid_hold", {grant, done, err, is_bus_busy}, 13'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    xfer('{4'b1010, 4'b0000, 1, 1'b0, 4'b0010, 1'b1, 32'h7777_0007}, 1'b0);

    // Randomized traffic against the transaction model
    req_read = '0; req_write = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = '0;
    mptr = 0; in_xfer = 1'b0; idle_from = -1;
    prev_pend = '0; act = '0;
    s = 0; d = 0; exp_end = 0; w = 0; w_rd = 1'b0; never = 1'b0; exp_rd = '0;
    for (int i = 0; i < 4; i++) begin
      opk[i] = 0; ra[i] = '0; rw[i] = '0;
    end
    for (c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      drop = '0;
      if (!in_xfer) begin
        exp_stb = (c >= idle_from + 2) && (prev_pend != 4'b0);
        if (exp_stb) begin
          w = 0;
          for (int k = 3; k >= 0; k--) if (prev_pend[(mptr + k) % 4]) w = (mptr + k) % 4;
          w_rd = (opk[w] != 1);
          check("rnd_issue_ctl", ctl(), {oh(w), 8'h00, 1'b1, w_rd, !w_rd});
          check("rnd_issue_bus", {addr_out, data_out}, {ra[w], w_rd ? 32'h0 : rw[w]});
          in_xfer = 1'b1;
          s       = c;
          never   = ($urandom_range(7) == 0);
          d       = $urandom_range(4);
          exp_end = never ? s + 1 + TO : s + d + 1;
        end else begin
          check("rnd_idle_ctl", ctl(), 15'h0);
        end
      end else if (c < exp_end) begin
        check("rnd_wait_ctl", ctl(), {oh(w), 8'h00, 1'b1, 2'b00});
        check("rnd_wait_bus", {addr_out, data_out}, {ra[w], w_rd ? 32'h0 : rw[w]});
      end else begin
        check("rnd_end_ctl", ctl(),
              {oh(w), never ? 4'b0 : oh(w), never ? oh(w) : 4'b0, 3'b000});
        check("rnd_end_addr", addr_out, 32'h0);
        if (!never && w_rd) last_rd = exp_rd;
        check("rnd_rdata", rdata, last_rd);
        mptr      = (w + 1) % 4;
        in_xfer   = 1'b0;
        idle_from = c;
        drop[w]   = 1'b1;
        act[w]    = 1'b0;
      end

      // bus responder for this cycle
      read_dn = 1'b0; write_dn = 1'b0; data_in = $urandom;
      if (in_xfer) begin
        if (!never && c == s + d) begin
          if (w_rd) read_dn = 1'b1; else write_dn = 1'b1;
          exp_rd = data_in;
        end else if ($urandom_range(3) == 0) begin
          if (w_rd) write_dn = 1'b1; else read_dn = 1'b1;
        end
      end

      // requesters: idle ones start a new access at random and hold it
      for (int i = 0; i < 4; i++) begin
        if (!act[i] && !drop[i] && $urandom_range(2) == 0) begin
          act[i] = 1'b1;
          opk[i] = $urandom_range(2);
          ra[i]  = $urandom;
          rw[i]  = $urandom;
        end
        req_read[i]           = act[i] && (opk[i] != 1);
        req_write[i]          = act[i] && (opk[i] != 0);
        req_addr[i*32 +: 32]  = ra[i];
        req_wdata[i*32 +: 32] = rw[i];
      end
      prev_pend = act;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
